lsu_dtcm_master: RTL and testbench
==================================

Name: lsu_dtcm_master

Overview:
Initiator side of the LSU-to-DTCM command/response interface. It accepts one load/store request at a time from the EXU and drives the cmd channel (valid/ready, read, address, write mask, write data). It then collects the rsp channel and returns formatted load data to writeback. It sits between the EXU and dtcm_ctrl, and owns alignment checking, byte-lane steering and sign/zero extension.

Parameters:
DW, 32, DTCM data width (matches `DTCM_RAM_DW)
MW, 4, write-mask width, DW/8 (matches `DTCM_RAM_MW)
AW, 16, DTCM byte-address width (matches `DTCM_ADDR_WIDTH)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
exu2lsu_req_valid  in  1  request valid
exu2lsu_req_ready  out  1  request accepted when valid&ready
exu2lsu_req_load  in  1  1=load, 0=store
exu2lsu_req_addr  in  32  byte address
exu2lsu_req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
exu2lsu_req_unsigned  in  1  zero-extend load when 1
exu2lsu_req_wdata  in  32  store data, right-justified
exu2lsu_req_rd  in  5  load destination register
lsu2dtcm_cmd_valid  out  1  command valid
lsu2dtcm_cmd_ready  in  1  responder accepts command
lsu2dtcm_cmd_read  out  1  1=read
lsu2dtcm_cmd_addr  out  AW  word-aligned byte address
lsu2dtcm_cmd_wmask  out  MW  byte write enables
lsu2dtcm_cmd_wdata  out  DW  lane-replicated store data
lsu2dtcm_rsp_valid  in  1  response valid
lsu2dtcm_rsp_ready  out  1  LSU accepts response
lsu2dtcm_rsp_rdata  in  DW  read data word
lsu_wb_valid  out  1  one-cycle load writeback pulse
lsu_wb_rd  out  5  writeback register
lsu_wb_data  out  32  extended load data
lsu_misalign_err  out  1  one-cycle misalignment/illegal-size pulse
lsu_busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE. All outputs are 0 except exu2lsu_req_ready=1. Captured request registers are cleared.
- Reset asserted mid-transaction discards the transaction: no wb_valid and no err are produced, and any later rsp_valid is ignored.
- FSM states: IDLE, CMD, RSP, DONE, ERR.
- IDLE:
  - req_ready=1.
  - On valid&ready, register load, addr, size, unsigned, wdata and rd.
  - Misaligned request goes to ERR: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Otherwise go to CMD.
- CMD:
  - cmd_valid=1 and rsp_ready=1. All cmd fields are held stable until cmd_ready.
  - On cmd_ready&rsp_valid in the same cycle (zero-wait responder), capture rdata and go to DONE.
  - On cmd_ready without rsp_valid, go to RSP.
  - Without cmd_ready, stay in CMD.
- RSP: cmd_valid=0, rsp_ready=1. On rsp_valid, capture rdata and go to DONE.
- DONE:
  - For a load, wb_valid=1 with wb_rd and wb_data.
  - For a store, no writeback; a store still waits for its rsp.
  - Next state is IDLE.
- ERR: misalign_err=1 for one cycle, no cmd issued, then IDLE.
- A new request is not accepted in DONE or ERR; req_ready is high only in IDLE.
- Latency with zero-wait responder: accept at cycle 0, cmd/rsp at cycle 1, wb_valid at cycle 2, req_ready again at cycle 3.
- Command encoding:
  - cmd_addr = {addr[AW-1:2], 2'b00}. Upper address bits are ignored.
  - Loads: cmd_read=1, wmask=0, wdata=0.
  - Store wmask: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<{addr[1],1'b0}; word gives 4'b1111.
  - Store wdata: byte gives {4{wdata[7:0]}}; half gives {2{wdata[15:0]}}; word gives wdata.
- Load formatting:
  - Select the byte/half lane by addr[1:0].
  - Sign-extend unless unsigned; word loads pass through.
- rsp_valid seen in IDLE, DONE or ERR is ignored (rsp_ready=0).

Decomposition:
- Shared defines file: size codes LSU_SIZE_B/H/W, FSM state encodings, and reuse of the existing DTCM width macros.
- One combinational sub-module, lsu_data_align, holds wmask and wdata generation, the misalign check, and load lane extraction with extension. The FSM and registers stay in lsu_dtcm_master.

Test Plan:
- Store word: addr=0x100, wdata=0xDEADBEEF, cmd_ready=1, rsp_valid tied to cmd_valid.
  - Expect cmd_addr=0x100, wmask=4'hF, wdata=0xDEADBEEF, cmd_read=0, no wb_valid, req_ready back at cycle 3.
- Store byte: addr=0x103, wdata=0x5A.
  - Expect wmask=4'b1000, wdata=0x5A5A5A5A.
- Load half, signed: addr=0x22, rdata=0x8001_1234.
  - Expect wb_data=0xFFFF8001 with the correct rd at cycle 2.
  - Same with unsigned=1: expect 0x00008001.
- Back-pressure: cmd_ready low for 3 cycles, then rsp_valid 2 cycles after cmd_ready.
  - Expect cmd fields stable while stalled, state RSP, exactly one wb_valid, req_ready=0 throughout.
- Misaligned word: addr=0x101.
  - Expect misalign_err one-cycle pulse, cmd_valid never asserted, IDLE next.
  - Repeat with size=11 and expect the same result.
- Reset asserted while in RSP, then a stray rsp_valid.
  - Expect all outputs reset next cycle, rsp ignored, no wb_valid.

Source files
------------

// File: rtl/lsu_dtcm_master_pkg.sv
// Shared types for the LSU-to-DTCM initiator: access size codes, FSM states,
// DTCM width defaults and the alignment rule used by the datapath.
package lsu_dtcm_master_pkg;

   localparam int unsigned LSU_DTCM_DW = 32;
   localparam int unsigned LSU_DTCM_MW = LSU_DTCM_DW / 8;
   localparam int unsigned LSU_DTCM_AW = 16;

   typedef enum logic [1:0] {
      LSU_SIZE_B = 2'b00,
      LSU_SIZE_H = 2'b01,
      LSU_SIZE_W = 2'b10,
      LSU_SIZE_X = 2'b11
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RSP,
      ST_DONE,
      ST_ERR
   } lsu_state_e;

   // The illegal size code is reported through the same path as misalignment.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (lsu_size_e'(size))
         LSU_SIZE_B: bad = 1'b0;
         LSU_SIZE_H: bad = addr_lo[0];
         LSU_SIZE_W: bad = |addr_lo;
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering: store mask/data replication, request
// alignment check, and load lane extraction with sign/zero extension.
module lsu_data_align
   import lsu_dtcm_master_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned MW = 4
) (
   input  logic [1:0]    chk_size_i,
   input  logic [1:0]    chk_addr_i,
   output logic          misalign_o,
   input  logic [1:0]    size_i,
   input  logic [1:0]    addr_i,
   input  logic [31:0]   wdata_i,
   input  logic          unsigned_i,
   input  logic [DW-1:0] rdata_i,
   output logic [MW-1:0] wmask_o,
   output logic [DW-1:0] wdata_o,
   output logic [31:0]   ldata_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign misalign_o = lsu_misaligned(chk_size_i, chk_addr_i);

   assign lane_b = rdata_i[{addr_i, 3'b000} +: 8];
   assign lane_h = rdata_i[{addr_i[1], 4'b0000} +: 16];

   always_comb begin
      wmask_o = '0;
      wdata_o = '0;
      ldata_o = '0;
      case (lsu_size_e'(size_i))
         LSU_SIZE_B: begin
            wmask_o = 4'b0001 << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
            ldata_o = unsigned_i ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         end
         LSU_SIZE_H: begin
            wmask_o = 4'b0011 << {addr_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            ldata_o = unsigned_i ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         end
         LSU_SIZE_W: begin
            wmask_o = '1;
            wdata_o = wdata_i;
            ldata_o = rdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_dtcm_master.sv
// LSU initiator on the DTCM cmd/rsp interface: one request in flight, with
// alignment checking and formatted load writeback.
module lsu_dtcm_master
   import lsu_dtcm_master_pkg::*;
#(
   parameter int unsigned DW = LSU_DTCM_DW,
   parameter int unsigned MW = LSU_DTCM_MW,
   parameter int unsigned AW = LSU_DTCM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exu2lsu_req_valid,
   output logic          exu2lsu_req_ready,
   input  logic          exu2lsu_req_load,
   input  logic [31:0]   exu2lsu_req_addr,
   input  logic [1:0]    exu2lsu_req_size,
   input  logic          exu2lsu_req_unsigned,
   input  logic [31:0]   exu2lsu_req_wdata,
   input  logic [4:0]    exu2lsu_req_rd,
   output logic          lsu2dtcm_cmd_valid,
   input  logic          lsu2dtcm_cmd_ready,
   output logic          lsu2dtcm_cmd_read,
   output logic [AW-1:0] lsu2dtcm_cmd_addr,
   output logic [MW-1:0] lsu2dtcm_cmd_wmask,
   output logic [DW-1:0] lsu2dtcm_cmd_wdata,
   input  logic          lsu2dtcm_rsp_valid,
   output logic          lsu2dtcm_rsp_ready,
   input  logic [DW-1:0] lsu2dtcm_rsp_rdata,
   output logic          lsu_wb_valid,
   output logic [4:0]    lsu_wb_rd,
   output logic [31:0]   lsu_wb_data,
   output logic          lsu_misalign_err,
   output logic          lsu_busy
);

   lsu_state_e    state_q, state_d;
   logic          load_q;
   logic [AW-1:0] addr_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [31:0]   wdata_q;
   logic [4:0]    rd_q;
   logic [DW-1:0] rdata_q;

   logic          accept, capture, misalign;
   logic [MW-1:0] al_wmask;
   logic [DW-1:0] al_wdata;
   logic [31:0]   al_ldata;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^exu2lsu_req_addr[31:AW];
   assign accept         = exu2lsu_req_valid & exu2lsu_req_ready;

   lsu_data_align #(
      .DW (DW),
      .MW (MW)
   ) u_align (
      .chk_size_i (exu2lsu_req_size),
      .chk_addr_i (exu2lsu_req_addr[1:0]),
      .misalign_o (misalign),
      .size_i     (size_q),
      .addr_i     (addr_q[1:0]),
      .wdata_i    (wdata_q),
      .unsigned_i (uns_q),
      .rdata_i    (rdata_q),
      .wmask_o    (al_wmask),
      .wdata_o    (al_wdata),
      .ldata_o    (al_ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         load_q  <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            load_q  <= exu2lsu_req_load;
            addr_q  <= exu2lsu_req_addr[AW-1:0];
            size_q  <= exu2lsu_req_size;
            uns_q   <= exu2lsu_req_unsigned;
            wdata_q <= exu2lsu_req_wdata;
            rd_q    <= exu2lsu_req_rd;
         end
         if (capture) rdata_q <= lsu2dtcm_rsp_rdata;
      end
   end

   always_comb begin
      state_d            = state_q;
      exu2lsu_req_ready  = 1'b0;
      lsu2dtcm_cmd_valid = 1'b0;
      lsu2dtcm_rsp_ready = 1'b0;
      lsu_wb_valid       = 1'b0;
      lsu_misalign_err   = 1'b0;
      capture            = 1'b0;
      case (state_q)
         ST_IDLE: begin
            exu2lsu_req_ready = 1'b1;
            if (exu2lsu_req_valid) state_d = misalign ? ST_ERR : ST_CMD;
         end
         ST_CMD: begin
            lsu2dtcm_cmd_valid = 1'b1;
            lsu2dtcm_rsp_ready = 1'b1;
            // A zero-wait responder answers in the same cycle the command is taken.
            if (lsu2dtcm_cmd_ready) begin
               capture = lsu2dtcm_rsp_valid;
               state_d = lsu2dtcm_rsp_valid ? ST_DONE : ST_RSP;
            end
         end
         ST_RSP: begin
            lsu2dtcm_rsp_ready = 1'b1;
            if (lsu2dtcm_rsp_valid) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            lsu_wb_valid = load_q;
            state_d      = ST_IDLE;
         end
         ST_ERR: begin
            lsu_misalign_err = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign lsu_busy           = (state_q != ST_IDLE);
   assign lsu2dtcm_cmd_read  = lsu2dtcm_cmd_valid & load_q;
   assign lsu2dtcm_cmd_addr  = lsu2dtcm_cmd_valid ? {addr_q[AW-1:2], 2'b00} : '0;
   assign lsu2dtcm_cmd_wmask = (lsu2dtcm_cmd_valid & ~load_q) ? al_wmask : '0;
   assign lsu2dtcm_cmd_wdata = (lsu2dtcm_cmd_valid & ~load_q) ? al_wdata : '0;
   assign lsu_wb_rd          = lsu_wb_valid ? rd_q : '0;
   assign lsu_wb_data        = lsu_wb_valid ? al_ldata : '0;

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// Scoreboard bench for lsu_dtcm_master: directed cases plus randomized
// requests checked against an arithmetic model of lane steering and extension.
module tb_lsu_dtcm_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_load = 1'b0, req_uns = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic [4:0]  req_rd = '0;
   logic        cmd_valid, cmd_ready = 1'b0, cmd_read;
   logic [15:0] cmd_addr;
   logic [3:0]  cmd_wmask;
   logic [31:0] cmd_wdata;
   logic        rsp_valid = 1'b0, rsp_ready;
   logic [31:0] rsp_rdata = '0;
   logic        wb_valid, err, busy;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int unsigned cyc = 0;
   int          n_vec = 0, n_bad = 0;

   typedef struct { logic rd_f; logic [15:0] addr; logic [3:0] wmask; logic [31:0] wdata; } cmd_t;
   typedef struct { int unsigned cy; logic [4:0] rd; logic [31:0] data; } wb_t;
   cmd_t        cmdq[$];
   wb_t         wbq[$];
   int unsigned errq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_dtcm_master #(.DW(32), .MW(4), .AW(16)) dut (
      .clk(clk), .rst(rst),
      .exu2lsu_req_valid(req_valid), .exu2lsu_req_ready(req_ready),
      .exu2lsu_req_load(req_load), .exu2lsu_req_addr(req_addr),
      .exu2lsu_req_size(req_size), .exu2lsu_req_unsigned(req_uns),
      .exu2lsu_req_wdata(req_wdata), .exu2lsu_req_rd(req_rd),
      .lsu2dtcm_cmd_valid(cmd_valid), .lsu2dtcm_cmd_ready(cmd_ready),
      .lsu2dtcm_cmd_read(cmd_read), .lsu2dtcm_cmd_addr(cmd_addr),
      .lsu2dtcm_cmd_wmask(cmd_wmask), .lsu2dtcm_cmd_wdata(cmd_wdata),
      .lsu2dtcm_rsp_valid(rsp_valid), .lsu2dtcm_rsp_ready(rsp_ready),
      .lsu2dtcm_rsp_rdata(rsp_rdata),
      .lsu_wb_valid(wb_valid), .lsu_wb_rd(wb_rd), .lsu_wb_data(wb_data),
      .lsu_misalign_err(err), .lsu_busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [3:0] m_wmask(input logic [1:0] sz, input logic [31:0] a);
      int unsigned nb = 1 << sz;
      return 4'(((1 << nb) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      int unsigned nb = 1 << sz;
      logic [63:0] v, r;
      v = {32'b0, wd} & ((64'd1 << (8 * nb)) - 1);
      r = '0;
      for (int i = 0; i < 4 / nb; i++) r |= v << (8 * nb * i);
      return r[31:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic un, input logic [31:0] rdat);
      int unsigned nb = 1 << sz;
      logic [63:0] mask, v;
      mask = (64'd1 << (8 * nb)) - 1;
      v    = ({32'b0, rdat} >> (8 * (a % 4))) & mask;
      if (!un && v[8 * nb - 1]) v |= ~mask;
      return v[31:0];
   endfunction

   // Monitor: compares every presented command beat, writeback and error pulse.
   always @(negedge clk) begin
      cmd_t ec;
      wb_t  ew;
      int unsigned ecy;
      if (!rst) begin
         if (cmd_valid) begin
            if (cmdq.size() == 0) chk("cmd_unexpected", cmd_valid, 0);
            else begin
               ec = cmdq[0];
               chk("cmd_read", cmd_read, ec.rd_f);
               chk("cmd_addr", cmd_addr, ec.addr);
               chk("cmd_wmask", cmd_wmask, ec.wmask);
               chk("cmd_wdata", cmd_wdata, ec.wdata);
               if (cmd_ready) void'(cmdq.pop_front());
            end
         end
         if (wb_valid) begin
            if (wbq.size() == 0) chk("wb_unexpected", wb_valid, 0);
            else begin
               ew = wbq.pop_front();
               chk("wb_cycle", cyc, ew.cy);
               chk("wb_rd", wb_rd, ew.rd);
               chk("wb_data", wb_data, ew.data);
            end
         end
         if (err) begin
            if (errq.size() == 0) chk("err_unexpected", err, 0);
            else begin
               ecy = errq.pop_front();
               chk("err_cycle", cyc, ecy);
            end
         end
      end
   end

   task automatic txn(input logic ld, input logic [31:0] a, input logic [1:0] sz, input logic un,
                      input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdat,
                      input int unsigned cw, input int unsigned rw);
      int unsigned acc, done_cy;
      bit bad;
      @(posedge clk); #1;
      req_valid = 1'b1; req_load = ld; req_addr = a; req_size = sz;
      req_uns = un; req_wdata = wd; req_rd = rd; rsp_rdata = rdat;
      acc = cyc;
      bad = m_misaligned(sz, a);
      if (bad) begin
         errq.push_back(acc + 1);
         done_cy = acc + 2;
      end else begin
         cmdq.push_back('{rd_f: ld, addr: 16'((a % 65536) - (a % 4)),
                          wmask: ld ? 4'h0 : m_wmask(sz, a), wdata: ld ? 32'h0 : m_wdata(sz, wd)});
         if (ld) wbq.push_back('{cy: acc + 2 + cw + rw, rd: rd, data: m_load(sz, a, un, rdat)});
         done_cy = acc + 3 + cw + rw;
      end
      @(negedge clk); chk("req_ready_idle", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      req_size = 2'($urandom); req_uns = 1'($urandom);
      if (!bad) begin
         repeat (cw) begin @(posedge clk); #1; end
         cmd_ready = 1'b1; rsp_valid = (rw == 0);
         @(negedge clk);
         chk("cmd_valid_hs", cmd_valid, 1);
         if (rw == 0) chk("rsp_ready_cmd", rsp_ready, 1);
         @(posedge clk); #1;
         cmd_ready = 1'b0; rsp_valid = 1'b0;
         if (rw != 0) begin
            repeat (rw - 1) begin @(posedge clk); #1; end
            rsp_valid = 1'b1;
            @(negedge clk);
            chk("rsp_state_cmd_valid", cmd_valid, 0);
            chk("rsp_ready_rsp", rsp_ready, 1);
            @(posedge clk); #1;
            rsp_valid = 1'b0;
         end
      end
      @(negedge clk);
      while (cyc < done_cy) begin
         chk("req_ready_busy", req_ready, 0);
         @(negedge clk);
      end
      chk("req_ready_back", req_ready, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_read", cmd_read, 0);
      chk("rst_cmd_addr", cmd_addr, 0);
      chk("rst_cmd_wmask", cmd_wmask, 0);
      chk("rst_cmd_wdata", cmd_wdata, 0);
      chk("rst_rsp_ready", rsp_ready, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      repeat (3) @(posedge clk);
      @(negedge clk); chk_reset_outputs();
      @(posedge clk); #1; rst = 1'b0;

      txn(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 0);
      txn(1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0000_005A, 5'd0, 32'h0, 0, 0);
      txn(1'b1, 32'h0000_0022, 2'd1, 1'b0, 32'h0, 5'd7, 32'h8001_1234, 0, 0);
      txn(1'b1, 32'h0000_0022, 2'd1, 1'b1, 32'h0, 5'd9, 32'h8001_1234, 0, 0);
      txn(1'b1, 32'hABCD_0048, 2'd0, 1'b0, 32'h0, 5'd3, 32'h1234_F6A5, 3, 2);
      txn(1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'h1111_2222, 5'd0, 32'h0, 0, 0);
      txn(1'b1, 32'h0000_0100, 2'd3, 1'b0, 32'h0, 5'd4, 32'h0, 0, 0);

      // Reset while waiting in RSP, followed by a stray response.
      @(posedge clk); #1;
      req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h40; req_size = 2'd2;
      req_uns = 1'b0; req_rd = 5'd11; rsp_rdata = 32'h1234_5678;
      cmdq.push_back('{rd_f: 1'b1, addr: 16'h0040, wmask: 4'h0, wdata: 32'h0});
      @(posedge clk); #1; req_valid = 1'b0; cmd_ready = 1'b1;
      @(posedge clk); #1; cmd_ready = 1'b0;
      @(negedge clk);
      chk("rsp_wait_busy", busy, 1);
      chk("rsp_wait_rsp_ready", rsp_ready, 1);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; rsp_valid = 1'b1;
      @(negedge clk); chk_reset_outputs();
      @(posedge clk); #1; rsp_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("wb_after_reset", wb_valid, 0);
         chk("busy_after_reset", busy, 0);
      end

      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
         txn(1'($urandom), a, sz, 1'($urandom), $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      end

      repeat (4) @(negedge clk);
      chk("cmdq_drained", cmdq.size(), 0);
      chk("wbq_drained", wbq.size(), 0);
      chk("errq_drained", errq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
